// File: rtl/ccff_loader.sv
// ccff_loader: streams configuration words MSB-first into the fabric
// configuration chain and packs the bits leaving the chain tail into
// readback words, so the previously loaded image can be compared.
`timescale 1ns/1ps

module ccff_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshake: a bitstream word transfers on every prog_clk edge where
  // bs_valid and bs_ready are both high. bs_ready never depends on
  // bs_valid, and the producer must hold bs_data stable while bs_valid is
  // high without bs_ready. rb_valid is a one-cycle pulse with no ready.

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W     = $clog2(WORD_W + 1);
  // Bits of the last, possibly partial, word and the zero padding that
  // left-aligns its readback.
  localparam int TAIL_BITS = CHAIN_LEN % WORD_W;
  localparam int PAD       = (TAIL_BITS == 0) ? 0 : (WORD_W - TAIL_BITS);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(WORD_W);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;          // outgoing word, MSB is next bit
  logic [IDX_W-1:0]  idx_q, idx_d;        // bits of current word still to shift
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // bits shifted so far in this load
  logic [WORD_W-1:0] rb_sh_q, rb_sh_d;    // tail bits being packed
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;

  logic last_bit;
  logic word_end;
  logic ready_c;

  // Decode of the bit being shifted this cycle.
  assign last_bit = (cnt_q == LAST_CNT);
  assign word_end = (idx_q == ONE_IDX);

  // Ready in FETCH, and as a prefetch on the last bit of a word when more
  // bits are still owed to the chain.
  assign ready_c = (state_q == ST_FETCH) ||
                   ((state_q == ST_SHIFT) && word_end && !last_bit);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rb_sh_d    = rb_sh_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    head_d     = 1'b0;
    shift_en_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end

      ST_FETCH: begin
        if (bs_valid) begin
          sr_d    = bs_data;
          idx_d   = FULL_IDX;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // The chain shifts on the edge ending this cycle; the tail value
        // captured here is the pre-shift bit.
        sr_d    = {sr_q[WORD_W-2:0], 1'b0};
        idx_d   = idx_q - ONE_IDX;
        cnt_d   = cnt_q + CNT_W'(1);
        rb_sh_d = {rb_sh_q[WORD_W-2:0], ccff_tail};

        if (last_bit) begin
          // Leftover low bits of the last word are dropped; the partial
          // readback word is left-aligned with zeros below it.
          state_d    = ST_DONE;
          rb_valid_d = 1'b1;
          rb_data_d  = rb_sh_d << PAD;
        end else if (word_end) begin
          rb_valid_d = 1'b1;
          rb_data_d  = rb_sh_d;
          if (bs_valid) begin
            sr_d  = bs_data;
            idx_d = FULL_IDX;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Chain drive is registered so the gated programming clock sees a
    // clean enable.
    if (state_d == ST_SHIFT) begin
      shift_en_d = 1'b1;
      head_d     = sr_d[WORD_W-1];
    end
  end

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rb_sh_q    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rb_sh_q    <= rb_sh_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
    end
  end

  assign bs_ready      = ready_c;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign rb_data       = rb_data_q;
  assign rb_valid      = rb_valid_q;
  assign busy          = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
  assign done          = (state_q == ST_DONE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (20-bit chain with 8-bit words, and
// 8-bit chain with 4-bit words), each driving a behavioural chain model.
// Expected head streams and readback words come from a bit-list image of
// the chain kept in queues.
`timescale 1ns/1ps

module tb_ccff_loader;

  localparam int L1 = 20;
  localparam int W1 = 8;
  localparam int L2 = 8;
  localparam int W2 = 4;
  localparam int BUDGET = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 1 ----------------
  logic          start1, bs_valid1, bs_ready1, head1, sen1, tail1, rb_valid1, busy1, done1;
  logic [W1-1:0] bs_data1, rb_data1;
  logic [1:0]    dbg1;

  ccff_loader #(.CHAIN_LEN(L1), .WORD_W(W1)) u_dut1 (
    .prog_clk(clk), .prog_reset(rst_n), .start(start1),
    .bs_data(bs_data1), .bs_valid(bs_valid1), .bs_ready(bs_ready1),
    .ccff_head(head1), .ccff_shift_en(sen1), .ccff_tail(tail1),
    .rb_data(rb_data1), .rb_valid(rb_valid1), .busy(busy1), .done(done1),
    .dbg_state(dbg1)
  );

  // ---------------- DUT 2 ----------------
  logic          start2, bs_valid2, bs_ready2, head2, sen2, tail2, rb_valid2, busy2, done2;
  logic [W2-1:0] bs_data2, rb_data2;
  logic [1:0]    dbg2;

  ccff_loader #(.CHAIN_LEN(L2), .WORD_W(W2)) u_dut2 (
    .prog_clk(clk), .prog_reset(rst_n), .start(start2),
    .bs_data(bs_data2), .bs_valid(bs_valid2), .bs_ready(bs_ready2),
    .ccff_head(head2), .ccff_shift_en(sen2), .ccff_tail(tail2),
    .rb_data(rb_data2), .rb_valid(rb_valid2), .busy(busy2), .done(done2),
    .dbg_state(dbg2)
  );

  // ---------------- chain models (bit 0 = first flop) ----------------
  logic [L1-1:0] chain1;
  logic [L2-1:0] chain2;
  logic          pre1_en = 1'b0;
  logic          pre2_en = 1'b0;
  logic [L1-1:0] pre1_val;
  logic [L2-1:0] pre2_val;

  always @(posedge clk) begin
    if (pre1_en) chain1 <= pre1_val;
    else if (sen1) chain1 <= {chain1[L1-2:0], head1};
  end

  always @(posedge clk) begin
    if (pre2_en) chain2 <= pre2_val;
    else if (sen2) chain2 <= {chain2[L2-2:0], head2};
  end

  assign tail1 = chain1[L1-1];
  assign tail2 = chain2[L2-1];

  // ---------------- model / scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic          img1_q[$];   // chain 1 contents, tail-first
  logic          img2_q[$];
  logic [W1-1:0] feed1_q[$];
  logic [W2-1:0] feed2_q[$];
  logic [W1-1:0] exp_q[$];    // expected readback words, DUT 1
  logic [W2-1:0] exp2_q[$];

  task automatic set_words1(input logic [W1-1:0] a, input logic [W1-1:0] b,
                            input logic [W1-1:0] c);
    feed1_q.delete();
    feed1_q.push_back(a);
    feed1_q.push_back(b);
    feed1_q.push_back(c);
    feed1_q.push_back(W1'($urandom));   // surplus word, must never be taken
  endtask

  // One load on DUT 1. stall_len: cycles bs_valid stays low while the
  // loader waits for word 2; mid_start: cycle to pulse start during the
  // load (0 = none); reset_bits: assert reset after this many bits (0 = none).
  task automatic run_load1(input int stall_len, input int mid_start, input int reset_bits);
    logic          nb[$];
    logic [W1-1:0] wd, acc, rb_exp;
    logic [L1-1:0] exp_vec;
    int cyc, hold, hs_cnt, sh_cnt, done_cyc, rb_idx, first_sh, gap, extra, exp_cyc, nwords;
    logic hs, aborted;
    nwords = (L1 + W1 - 1) / W1;
    extra  = (stall_len > 0) ? stall_len + 1 : 0;
    for (int k = 0; k < L1; k++) begin
      wd = feed1_q[k / W1];
      nb.push_back(wd[W1-1-(k % W1)]);
    end
    exp_q.delete();
    for (int k = 0; k < L1; k += W1) begin
      acc = '0;
      for (int j = 0; j < W1; j++) if (k + j < L1) acc[W1-1-j] = img1_q[k+j];
      exp_q.push_back(acc);
    end

    start1 = 1'b1;
    bs_valid1 = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 1; hold = 0; hs_cnt = 0; sh_cnt = 0; done_cyc = -1; rb_idx = 0;
    first_sh = -1; gap = 0; aborted = 1'b0;

    while (cyc < BUDGET && done_cyc < 0 && !aborted) begin
      start1    = (cyc == mid_start);
      bs_valid1 = (hold == 0) && (feed1_q.size() > 0);
      bs_data1  = (feed1_q.size() > 0) ? feed1_q[0] : W1'($urandom);
      @(negedge clk);
      if (cyc == 1) begin
        n_cmp++;
        if ({bs_ready1, busy1, done1, sen1} !== 4'b1100) begin
          n_bad++;
          $display("FAIL start_to_fetch: got ready/busy/done/shift=%b expected 1100",
                   {bs_ready1, busy1, done1, sen1});
        end
      end
      hs = bs_ready1 && bs_valid1;
      if (sen1) begin
        n_cmp++;
        if (sh_cnt >= L1) begin
          n_bad++;
          $display("FAIL shift_count: got shift #%0d expected at most %0d", sh_cnt + 1, L1);
        end else if (head1 !== nb[sh_cnt]) begin
          n_bad++;
          $display("FAIL head_bit[%0d]: got %b expected %b", sh_cnt, head1, nb[sh_cnt]);
        end
        if (first_sh < 0) first_sh = cyc;
        sh_cnt++;
      end else if (first_sh >= 0 && sh_cnt < L1) begin
        gap++;
      end
      if (rb_valid1) begin
        exp_cyc = 2 + (((rb_idx + 1) * W1 < L1) ? (rb_idx + 1) * W1 : L1) +
                  ((rb_idx > 0) ? extra : 0);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rb_extra: got word %h expected no more words", rb_data1);
        end else begin
          rb_exp = exp_q.pop_front();
          if (rb_data1 !== rb_exp) begin
            n_bad++;
            $display("FAIL rb_data[%0d]: got %h expected %h", rb_idx, rb_data1, rb_exp);
          end
        end
        n_cmp++;
        if (cyc != exp_cyc) begin
          n_bad++;
          $display("FAIL rb_cycle[%0d]: got cycle %0d expected %0d", rb_idx, cyc, exp_cyc);
        end
        rb_idx++;
      end
      if (done1) done_cyc = cyc;
      if (reset_bits > 0 && sh_cnt == reset_bits) begin
        @(posedge clk); #1;
        n_cmp++;
        if (sen1 !== 1'b1) begin
          n_bad++;
          $display("FAIL shift_before_reset: got %b expected 1", sen1);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bs_ready1, head1, sen1, rb_data1, rb_valid1, busy1, done1} !== '0) begin
          n_bad++;
          $display("FAIL async_reset_outputs: got %h expected 0",
                   {bs_ready1, head1, sen1, rb_data1, rb_valid1, busy1, done1});
        end
        start1 = 1'b0;
        bs_valid1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (hs) begin
          void'(feed1_q.pop_front());
          hs_cnt++;
          if (hs_cnt == 1 && stall_len > 0) hold = W1 + stall_len;
        end else if (hold > 0) begin
          hold--;
        end
        cyc++;
      end
    end

    if (!aborted) begin
      n_cmp++;
      if (done_cyc != 2 + L1 + extra) begin
        n_bad++;
        $display("FAIL done_cycle: got %0d expected %0d (-1 = timeout)", done_cyc, 2 + L1 + extra);
      end
      n_cmp++;
      if (sh_cnt != L1) begin
        n_bad++;
        $display("FAIL shift_total: got %0d expected %0d", sh_cnt, L1);
      end
      n_cmp++;
      if (hs_cnt != nwords) begin
        n_bad++;
        $display("FAIL handshakes: got %0d expected %0d", hs_cnt, nwords);
      end
      n_cmp++;
      if (gap != extra) begin
        n_bad++;
        $display("FAIL shift_gap: got %0d expected %0d", gap, extra);
      end
      n_cmp++;
      if (rb_idx != nwords) begin
        n_bad++;
        $display("FAIL rb_words: got %0d expected %0d", rb_idx, nwords);
      end
      repeat (2) begin
        @(posedge clk); #1;
        bs_valid1 = 1'b1;
        bs_data1  = W1'($urandom);
        @(negedge clk);
        n_cmp++;
        if ({bs_ready1, sen1, busy1, done1} !== 4'b0001) begin
          n_bad++;
          $display("FAIL done_hold: got ready/shift/busy/done=%b expected 0001",
                   {bs_ready1, sen1, busy1, done1});
        end
      end
      bs_valid1 = 1'b0;
      img1_q.delete();
      for (int i = 0; i < L1; i++) img1_q.push_back(nb[i]);
    end else begin
      for (int i = 0; i < reset_bits; i++) begin
        void'(img1_q.pop_front());
        img1_q.push_back(nb[i]);
      end
    end

    for (int i = 0; i < L1; i++) exp_vec[L1-1-i] = img1_q[i];
    n_cmp++;
    if (chain1 !== exp_vec) begin
      n_bad++;
      $display("FAIL chain_image: got %h expected %h", chain1, exp_vec);
    end
    feed1_q.delete();
  endtask

  // One load on DUT 2 (chain length an exact multiple of the word width).
  task automatic run_load2();
    logic          nb[$];
    logic [W2-1:0] wd, acc, rb_exp;
    logic [L2-1:0] exp_vec;
    int cyc, hs_cnt, sh_cnt, done_cyc, rb_idx, first_sh, gap, exp_cyc;
    logic hs;
    for (int k = 0; k < L2; k++) begin
      wd = feed2_q[k / W2];
      nb.push_back(wd[W2-1-(k % W2)]);
    end
    exp2_q.delete();
    for (int k = 0; k < L2; k += W2) begin
      acc = '0;
      for (int j = 0; j < W2; j++) acc[W2-1-j] = img2_q[k+j];
      exp2_q.push_back(acc);
    end
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 1; hs_cnt = 0; sh_cnt = 0; done_cyc = -1; rb_idx = 0; first_sh = -1; gap = 0;
    while (cyc < BUDGET && done_cyc < 0) begin
      bs_valid2 = (feed2_q.size() > 0);
      bs_data2  = (feed2_q.size() > 0) ? feed2_q[0] : W2'($urandom);
      @(negedge clk);
      hs = bs_ready2 && bs_valid2;
      if (sen2) begin
        n_cmp++;
        if (sh_cnt >= L2) begin
          n_bad++;
          $display("FAIL w4_shift_count: got shift #%0d expected at most %0d", sh_cnt + 1, L2);
        end else if (head2 !== nb[sh_cnt]) begin
          n_bad++;
          $display("FAIL w4_head_bit[%0d]: got %b expected %b", sh_cnt, head2, nb[sh_cnt]);
        end
        if (first_sh < 0) first_sh = cyc;
        sh_cnt++;
      end else if (first_sh >= 0 && sh_cnt < L2) begin
        gap++;
      end
      if (rb_valid2) begin
        exp_cyc = 2 + (rb_idx + 1) * W2;
        n_cmp++;
        if (exp2_q.size() == 0) begin
          n_bad++;
          $display("FAIL w4_rb_extra: got word %h expected no more words", rb_data2);
        end else begin
          rb_exp = exp2_q.pop_front();
          if (rb_data2 !== rb_exp) begin
            n_bad++;
            $display("FAIL w4_rb_data[%0d]: got %h expected %h", rb_idx, rb_data2, rb_exp);
          end
        end
        n_cmp++;
        if (cyc != exp_cyc) begin
          n_bad++;
          $display("FAIL w4_rb_cycle[%0d]: got cycle %0d expected %0d", rb_idx, cyc, exp_cyc);
        end
        rb_idx++;
      end
      if (done2) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        if (hs) begin
          void'(feed2_q.pop_front());
          hs_cnt++;
        end
        cyc++;
      end
    end
    bs_valid2 = 1'b0;
    n_cmp++;
    if (done_cyc != 2 + L2) begin
      n_bad++;
      $display("FAIL w4_done_cycle: got %0d expected %0d (-1 = timeout)", done_cyc, 2 + L2);
    end
    n_cmp++;
    if (sh_cnt != L2 || gap != 0) begin
      n_bad++;
      $display("FAIL w4_shifts: got %0d shifts with %0d gaps expected %0d with 0", sh_cnt, gap, L2);
    end
    n_cmp++;
    if (hs_cnt != L2 / W2 || rb_idx != L2 / W2) begin
      n_bad++;
      $display("FAIL w4_words: got %0d handshakes %0d readbacks expected %0d each",
               hs_cnt, rb_idx, L2 / W2);
    end
    img2_q.delete();
    for (int i = 0; i < L2; i++) img2_q.push_back(nb[i]);
    for (int i = 0; i < L2; i++) exp_vec[L2-1-i] = img2_q[i];
    n_cmp++;
    if (chain2 !== exp_vec) begin
      n_bad++;
      $display("FAIL w4_chain_image: got %h expected %h", chain2, exp_vec);
    end
    feed2_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b0; bs_valid1 = 1'b0; bs_data1 = '0;
    start2 = 1'b0; bs_valid2 = 1'b0; bs_data2 = '0;
    pre1_val = '1;
    pre2_val = L2'($urandom);
    pre1_en = 1'b1;
    pre2_en = 1'b1;
    @(posedge clk); #1;
    pre1_en = 1'b0;
    pre2_en = 1'b0;
    img1_q.delete();
    img2_q.delete();
    for (int i = 0; i < L1; i++) img1_q.push_back(pre1_val[L1-1-i]);
    for (int i = 0; i < L2; i++) img2_q.push_back(pre2_val[L2-1-i]);
    @(negedge clk);
    n_cmp++;
    if ({bs_ready1, head1, sen1, rb_data1, rb_valid1, busy1, done1} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bs_ready1, head1, sen1, rb_data1, rb_valid1, busy1, done1});
    end
    n_cmp++;
    if ({bs_ready2, head2, sen2, rb_data2, rb_valid2, busy2, done2} !== '0) begin
      n_bad++;
      $display("FAIL w4_reset_outputs: got %h expected 0",
               {bs_ready2, head2, sen2, rb_data2, rb_valid2, busy2, done2});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bs_ready1, sen1, busy1, done1} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_outputs: got %b expected 0000", {bs_ready1, sen1, busy1, done1});
    end
  endtask

  task automatic test_basic_load();
    set_words1(8'hA5, 8'h3C, 8'hF0);
    run_load1(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    set_words1(8'hA5, 8'h3C, 8'hF0);
    run_load1(0, 0, 0);
    repeat (3) begin
      set_words1(W1'($urandom), W1'($urandom), W1'($urandom));
      run_load1(0, 0, 0);
    end
  endtask

  task automatic test_stall();
    set_words1(W1'($urandom), W1'($urandom), W1'($urandom));
    run_load1(5, 0, 0);
  endtask

  task automatic test_start_ignored();
    set_words1(W1'($urandom), W1'($urandom), W1'($urandom));
    run_load1(0, 10, 0);
  endtask

  task automatic test_reset_mid_load();
    set_words1(W1'($urandom), W1'($urandom), W1'($urandom));
    run_load1(0, 0, 11);
    set_words1(8'h00, 8'h00, 8'h00);
    run_load1(0, 0, 0);
  endtask

  task automatic test_exact_multiple();
    repeat (2) begin
      feed2_q.delete();
      feed2_q.push_back(W2'($urandom));
      feed2_q.push_back(W2'($urandom));
      feed2_q.push_back(W2'($urandom));
      run_load2();
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_stall();
    test_start_ignored();
    test_reset_mid_load();
    test_exact_multiple();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1, "watchdog");
  end

endmodule
